// File: rtl/encoder_pkg.sv
// Shared types and constants for the 4-to-2 request encoder.
// State encodings, widths and a code-to-one-hot helper.
package encoder_pkg;

  localparam int NUM_REQ = 4;
  localparam int CODE_W  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] code2oh(
    input logic [CODE_W-1:0] c
  );
    logic [NUM_REQ-1:0] oh;
    oh    = '0;
    oh[c] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/round_robin_pick_4.sv
// Combinational round-robin pick over 4 candidates.
// Ports: cand_i candidates, ptr_i start index; idx_o pick, any_o any set.
import encoder_pkg::*;

module round_robin_pick_4 (
  input  logic [NUM_REQ-1:0] cand_i,
  input  logic [CODE_W-1:0]  ptr_i,
  output logic [CODE_W-1:0]  idx_o,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [CODE_W-1:0]    off;

  always_comb begin
    // rotate so that bit ptr lands at position 0
    dbl = {cand_i, cand_i} >> ptr_i;
    rot = dbl[NUM_REQ-1:0];
    off = '0;
    priority casez (rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
    // un-rotate; 2-bit add wraps mod 4
    idx_o = off + ptr_i;
    any_o = |cand_i;
  end

endmodule

// File: rtl/request_encoder_4_to_2.sv
// Sequential 4-to-2 request encoder with round-robin grant and ack.
// Ports: req/ack/clr_ovr in; sel/valid/pending/overrun registered out.
import encoder_pkg::*;

module request_encoder_4_to_2 (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                ack,
  input  logic                clr_ovr,
  output logic [CODE_W-1:0]   sel,
  output logic                valid,
  output logic [NUM_REQ-1:0]  pending,
  output logic                overrun
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [CODE_W-1:0]  ptr_q, ptr_d;
  logic [CODE_W-1:0]  sel_q, sel_d;
  logic               ovr_q, ovr_d;

  logic               accept;
  logic [NUM_REQ-1:0] clr_mask;
  logic [NUM_REQ-1:0] idle_cand;
  logic [CODE_W-1:0]  idle_idx, ack_idx;
  logic               idle_any, ack_any;

  assign accept    = (state_q == ST_GRANT) & ack;
  assign clr_mask  = accept ? code2oh(sel_q) : '0;
  // set wins over the ack clear on the same line
  assign pend_d    = (pend_q & ~clr_mask) | req;
  assign idle_cand = pend_q | req;
  assign ptr_d     = accept ? sel_q + 2'd1 : ptr_q;

  round_robin_pick_4 u_pick_idle (
    .cand_i (idle_cand),
    .ptr_i  (ptr_q),
    .idx_o  (idle_idx),
    .any_o  (idle_any)
  );

  // post-ack pick already sees the advanced pointer
  round_robin_pick_4 u_pick_ack (
    .cand_i (pend_d),
    .ptr_i  (ptr_d),
    .idx_o  (ack_idx),
    .any_o  (ack_any)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      ST_IDLE: begin
        if (idle_any) begin
          sel_d   = idle_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (ack) begin
          if (ack_any) begin
            sel_d = ack_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // a new overrun outranks a simultaneous clear
  always_comb begin
    ovr_d = ovr_q;
    if (|(req & pend_q & ~clr_mask)) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sel     = sel_q;
  assign valid   = (state_q == ST_GRANT);
  assign pending = pend_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_request_encoder_4_to_2.sv
// Self-checking bench for request_encoder_4_to_2.
// Directed plan items plus random traffic against a reference model.
module tb_request_encoder_4_to_2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic       ack = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [1:0] sel;
  logic       valid;
  logic [3:0] pending;
  logic       overrun;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [3:0] m_pend;
  logic [1:0] m_ptr;
  logic [1:0] m_sel;
  logic       m_valid;
  logic       m_ovr;

  request_encoder_4_to_2 dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .clr_ovr (clr_ovr),
    .sel     (sel),
    .valid   (valid),
    .pending (pending),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_pend  = '0;
    m_ptr   = '0;
    m_sel   = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // one clock of the behaviour: clear acked line, merge requests,
  // then scan from the pointer for the next line to present
  task automatic m_step(input logic [3:0] r,
                        input logic a,
                        input logic c);
    logic [3:0] cm;
    logic [3:0] np;
    logic       ov;
    logic       found;
    logic [1:0] j;
    cm = '0;
    if (m_valid && a) cm[m_sel] = 1'b1;
    np = (m_pend & ~cm) | r;
    ov = (r & m_pend & ~cm) != 4'd0;
    if (m_valid && a) m_ptr = m_sel + 2'd1;
    if (!m_valid || a) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        j = m_ptr + 2'(k);
        if (!found && np[j]) begin
          found = 1'b1;
          m_sel = j;
        end
      end
      m_valid = found;
    end
    m_pend = np;
    if (ov) m_ovr = 1'b1;
    else if (c) m_ovr = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 8'(valid), 8'(m_valid));
    chk({tag, "_sel"}, 8'(sel), 8'(m_sel));
    chk({tag, "_pend"}, 8'(pending), 8'(m_pend));
    chk({tag, "_ovr"}, 8'(overrun), 8'(m_ovr));
  endtask

  task automatic step(input logic [3:0] r,
                      input logic a,
                      input logic c,
                      input string tag);
    req = r;
    ack = a;
    clr_ovr = c;
    @(posedge clk);
    m_step(r, a, c);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_reset();
    check_all("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    m_reset();
    req = '0;
    ack = 1'b0;
    clr_ovr = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // single request
    step(4'b0100, 1'b0, 1'b0, "single");
    chk("single_sel_c", 8'(sel), 8'd2);
    chk("single_vld_c", 8'(valid), 8'd1);
    step(4'b0000, 1'b1, 1'b0, "single_ack");
    chk("single_ack_vld_c", 8'(valid), 8'd0);

    // burst from reset
    do_reset();
    step(4'b1111, 1'b1, 1'b0, "burst0");
    chk("burst0_c", 8'(sel), 8'd0);
    step(4'b0000, 1'b1, 1'b0, "burst1");
    chk("burst1_c", 8'(sel), 8'd1);
    step(4'b0000, 1'b1, 1'b0, "burst2");
    chk("burst2_c", 8'(sel), 8'd2);
    step(4'b0000, 1'b1, 1'b0, "burst3");
    chk("burst3_c", 8'(sel), 8'd3);
    step(4'b0000, 1'b1, 1'b0, "burst_end");
    chk("burst_end_c", 8'(valid), 8'd0);

    // wrap-around: pointer wrapped to 0 after granting 3
    step(4'b1001, 1'b0, 1'b0, "wrap0");
    chk("wrap0_c", 8'(sel), 8'd0);
    step(4'b0000, 1'b1, 1'b0, "wrap1");
    chk("wrap1_c", 8'(sel), 8'd3);
    step(4'b0000, 1'b1, 1'b0, "wrap_end");

    // re-request on ack
    step(4'b1010, 1'b0, 1'b0, "rereq0");
    chk("rereq0_c", 8'(sel), 8'd1);
    step(4'b0010, 1'b1, 1'b0, "rereq1");
    chk("rereq1_pend_c", 8'(pending), 8'b1010);
    chk("rereq1_ovr_c", 8'(overrun), 8'd0);
    chk("rereq1_sel_c", 8'(sel), 8'd3);
    step(4'b0000, 1'b1, 1'b0, "rereq2");
    chk("rereq2_sel_c", 8'(sel), 8'd1);

    // overrun on line 1 still pending and unacked
    step(4'b0010, 1'b0, 1'b0, "ovr0");
    chk("ovr0_c", 8'(overrun), 8'd1);
    step(4'b0000, 1'b0, 1'b0, "ovr_hold");
    step(4'b0010, 1'b0, 1'b1, "ovr_setwin");
    chk("ovr_setwin_c", 8'(overrun), 8'd1);
    step(4'b0000, 1'b0, 1'b1, "ovr_clr");
    chk("ovr_clr_c", 8'(overrun), 8'd0);

    // reset mid-grant with pending 1010
    step(4'b1000, 1'b0, 1'b0, "pre_rst");
    chk("pre_rst_c", 8'(pending), 8'b1010);
    #3;
    do_reset();
    chk("rst_mid_vld_c", 8'(valid), 8'd0);
    step(4'b0000, 1'b0, 1'b0, "post_rst");
    step(4'b0000, 1'b1, 1'b0, "post_rst_ack");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      step(r, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
